rom_port_arbiter: RTL and testbench



---
 rtl/rom_port_arbiter_if.sv | 46 ++++
 rtl/rom_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_rom_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
// Bundle of the two requester ports, the ROM read port and the arbiter status.
// The arbiter takes the slave modport; the surrounding system drives the master side.
interface rom_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] a_addr;
    logic              a_read_en;
    logic [DATA_W-1:0] a_data_out;
    logic              a_ready;
    logic              a_err;

    logic [ADDR_W-1:0] b_addr;
    logic              b_read_en;
    logic [DATA_W-1:0] b_data_out;
    logic              b_ready;
    logic              b_err;

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_read_en;
    logic [DATA_W-1:0] rom_data_out;
    logic              rom_ready;

    logic [1:0]        owner;
    logic              timeout_err;

    modport slave (
        input  a_addr, a_read_en,
        output a_data_out, a_ready, a_err,
        input  b_addr, b_read_en,
        output b_data_out, b_ready, b_err,
        output rom_addr, rom_read_en,
        input  rom_data_out, rom_ready,
        output owner, timeout_err
    );

    modport master (
        output a_addr, a_read_en,
        input  a_data_out, a_ready, a_err,
        output b_addr, b_read_en,
        input  b_data_out, b_ready, b_err,
        input  rom_addr, rom_read_en,
        output rom_data_out, rom_ready,
        input  owner, timeout_err
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one ROM read port between loader (A) and fetch (B),
// with a bounded burst lock for the current owner and a watchdog on stuck accesses.
module rom_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    rom_port_arbiter_if.slave  bus
);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned WD_W    = $clog2(TIMEOUT);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               rom_read_en_q, rom_read_en_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               rr_last_q, rr_last_d;   // 1 = B was the last new winner
    logic               timeout_err_q, timeout_err_d;
    logic               a_err_q, a_err_d;
    logic               b_err_q, b_err_d;

    logic               a_req, b_req, own_req, other_req;
    logic               grant, win_b;
    logic [1:0]         win_own;
    logic [DATA_W-1:0]  rom_data;

    assign a_req     = bus.a_read_en;
    assign b_req     = bus.b_read_en;
    assign own_req   = (owner_q == OWN_A && a_req) || (owner_q == OWN_B && b_req);
    assign other_req = (owner_q == OWN_A) ? b_req : a_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_NONE;
            rom_addr_q    <= '0;
            rom_read_en_q <= 1'b0;
            burst_q       <= '0;
            wd_q          <= '0;
            rr_last_q     <= 1'b1;
            timeout_err_q <= 1'b0;
            a_err_q       <= 1'b0;
            b_err_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rom_addr_q    <= rom_addr_d;
            rom_read_en_q <= rom_read_en_d;
            burst_q       <= burst_d;
            wd_q          <= wd_d;
            rr_last_q     <= rr_last_d;
            timeout_err_q <= timeout_err_d;
            a_err_q       <= a_err_d;
            b_err_q       <= b_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rom_addr_d    = rom_addr_q;
        rom_read_en_d = rom_read_en_q;
        burst_d       = burst_q;
        wd_d          = wd_q;
        rr_last_d     = rr_last_q;
        timeout_err_d = timeout_err_q;
        a_err_d       = 1'b0;
        b_err_d       = 1'b0;
        grant         = 1'b0;
        win_b         = 1'b0;
        win_own       = OWN_NONE;

        case (state_q)
            IDLE: begin
                // Lock first, then round-robin on a tie, else the lone requester.
                if (own_req && (!other_req || burst_q < BURST_W'(MAX_BURST))) begin
                    grant = 1'b1;
                    win_b = (owner_q == OWN_B);
                end else if (a_req && b_req) begin
                    grant = 1'b1;
                    win_b = !rr_last_q;
                end else if (a_req || b_req) begin
                    grant = 1'b1;
                    win_b = b_req;
                end

                if (grant) begin
                    win_own = win_b ? OWN_B : OWN_A;
                    if (win_own != owner_q) begin
                        burst_d   = BURST_W'(1);
                        rr_last_d = win_b;
                    end else if (burst_q < BURST_W'(MAX_BURST)) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                    owner_d       = win_own;
                    rom_addr_d    = win_b ? bus.b_addr : bus.a_addr;
                    rom_read_en_d = 1'b1;
                    wd_d          = '0;
                    state_d       = BUSY;
                end else begin
                    owner_d = OWN_NONE;
                    burst_d = '0;
                end
            end

            BUSY: begin
                // A ready arriving on the expiry cycle takes precedence over the abort.
                if (bus.rom_ready) begin
                    rom_read_en_d = 1'b0;
                    state_d       = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    rom_read_en_d = 1'b0;
                    state_d       = IDLE;
                    owner_d       = OWN_NONE;
                    timeout_err_d = 1'b1;
                    a_err_d       = (owner_q == OWN_A);
                    b_err_d       = (owner_q == OWN_B);
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Completion is forwarded combinationally to the current owner only.
    assign rom_data        = bus.rom_data_out;
    assign bus.a_data_out  = rom_data;
    assign bus.b_data_out  = rom_data;
    assign bus.a_ready     = (state_q == BUSY) && (owner_q == OWN_A) && bus.rom_ready;
    assign bus.b_ready     = (state_q == BUSY) && (owner_q == OWN_B) && bus.rom_ready;
    assign bus.a_err       = a_err_q;
    assign bus.b_err       = b_err_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.rom_read_en = rom_read_en_q;
    assign bus.owner       = owner_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: ROM model with programmable latency,
// per-port expected-data queues and checks on grant order, timing and errors.
module tb_rom_port_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    rom_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4), .TIMEOUT(10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int rom_delay = 1;
    int rom_cnt   = 0;
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    int order[$];
    int acyc[$];

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] addr);
        return addr[7:0] ^ addr[15:8] ^ 8'hA5;
    endfunction

    assign ifc.rom_data_out = rom_fn(ifc.rom_addr);

    // ROM: ready pulses rom_delay cycles after the first strobe cycle
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ifc.rom_ready = 1'b0;
            rom_cnt = 0;
        end else if (ifc.rom_ready) begin
            ifc.rom_ready = 1'b0;
            rom_cnt = 0;
        end else if (ifc.rom_read_en) begin
            rom_cnt++;
            if (rom_cnt == rom_delay + 1) ifc.rom_ready = 1'b1;
        end else begin
            rom_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.a_read_en = 1'b0;
        ifc.b_read_en = 1'b0;
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rom_read_en", ifc.rom_read_en, 0);
        chk("rst_rom_addr", ifc.rom_addr, 0);
        chk("rst_owner", ifc.owner, 0);
        chk("rst_timeout_err", ifc.timeout_err, 0);
        chk("rst_ready", {ifc.a_ready, ifc.b_ready}, 0);
        chk("rst_err", {ifc.a_err, ifc.b_err}, 0);
        rst_n = 1'b1;
    endtask

    // Drive na beats on A and nb beats on B (each starting at its delay cycle).
    task automatic serve(input int na, input logic [ADDR_W-1:0] abase, input int adelay,
                         input int nb, input logic [ADDR_W-1:0] bbase, input int bdelay,
                         input int limit);
        int da = 0;
        int db = 0;
        int cyc = 0;
        logic pend;
        logic [DATA_W-1:0] exp;
        order.delete();
        acyc.delete();
        if (na > 0 && adelay == 0) begin
            ifc.a_addr = abase; ifc.a_read_en = 1'b1; qa.push_back(rom_fn(abase));
        end
        if (nb > 0 && bdelay == 0) begin
            ifc.b_addr = bbase; ifc.b_read_en = 1'b1; qb.push_back(rom_fn(bbase));
        end
        while ((da < na || db < nb) && cyc < limit) begin
            @(posedge clk);
            #2;
            cyc++;
            chk("a_err_quiet", ifc.a_err, 0);
            chk("b_err_quiet", ifc.b_err, 0);
            if (ifc.rom_read_en && ifc.owner == 2'b01) chk("rom_addr_a", ifc.rom_addr, ifc.a_addr);
            if (ifc.rom_read_en && ifc.owner == 2'b10) chk("rom_addr_b", ifc.rom_addr, ifc.b_addr);
            if (ifc.a_ready) begin
                chk("a_owner", ifc.owner, 2'b01);
                chk("a_b_excl", ifc.b_ready, 0);
                pend = (qa.size() != 0);
                chk("a_ready_pending", pend, 1);
                if (pend) begin
                    exp = qa.pop_front();
                    chk("a_data", ifc.a_data_out, exp);
                end
                order.push_back(0);
                acyc.push_back(cyc);
                da++;
                if (da < na) begin
                    ifc.a_addr = abase + ADDR_W'(da);
                    qa.push_back(rom_fn(ifc.a_addr));
                end else begin
                    ifc.a_read_en = 1'b0;
                end
            end
            if (ifc.b_ready) begin
                chk("b_owner", ifc.owner, 2'b10);
                pend = (qb.size() != 0);
                chk("b_ready_pending", pend, 1);
                if (pend) begin
                    exp = qb.pop_front();
                    chk("b_data", ifc.b_data_out, exp);
                end
                order.push_back(1);
                db++;
                if (db < nb) begin
                    ifc.b_addr = bbase + ADDR_W'(db);
                    qb.push_back(rom_fn(ifc.b_addr));
                end else begin
                    ifc.b_read_en = 1'b0;
                end
            end
            if (na > 0 && adelay != 0 && cyc == adelay) begin
                ifc.a_addr = abase; ifc.a_read_en = 1'b1; qa.push_back(rom_fn(abase));
            end
            if (nb > 0 && bdelay != 0 && cyc == bdelay) begin
                ifc.b_addr = bbase; ifc.b_read_en = 1'b1; qb.push_back(rom_fn(bbase));
            end
        end
        chk("serve_done", (da == na && db == nb), 1);
    endtask

    initial begin
        int r;
        int f;
        int cyc;
        logic seen;
        int exp_order[$];

        ifc.a_addr = '0; ifc.a_read_en = 1'b0;
        ifc.b_addr = '0; ifc.b_read_en = 1'b0;
        ifc.rom_ready = 1'b0;

        // A-only stream, 1-cycle ROM latency, 3-cycle beat period
        do_reset();
        rom_delay = 1;
        serve(8, 32'h30, 0, 0, 32'h0, 0, 100);
        chk("a_stream_len", order.size(), 8);
        if (acyc.size() == 8) begin
            chk("a_first_latency", acyc[0], 2);
            for (int i = 1; i < 8; i++) chk("a_beat_period", acyc[i] - acyc[i-1], 3);
        end

        // Both request from reset: A first, bursts of 4 alternate
        do_reset();
        serve(8, 32'h1000, 0, 8, 32'h2000, 0, 200);
        chk("alt_len", order.size(), 16);
        if (order.size() == 16)
            for (int i = 0; i < 16; i++) chk("alt_order", order[i], (i / 4) % 2);

        // B alone, A arrives mid-burst: B keeps the port until its 4-beat limit
        do_reset();
        serve(2, 32'h3000, 4, 6, 32'h4000, 0, 200);
        exp_order = '{1, 1, 1, 1, 0, 0, 1, 1};
        chk("bburst_len", order.size(), 8);
        if (order.size() == 8)
            for (int i = 0; i < 8; i++) chk("bburst_order", order[i], exp_order[i]);

        // B drops request before the limit: A served at the next IDLE
        do_reset();
        serve(3, 32'h3100, 3, 2, 32'h4100, 0, 200);
        exp_order = '{1, 1, 0, 0, 0};
        chk("bdrop_len", order.size(), 5);
        if (order.size() == 5)
            for (int i = 0; i < 5; i++) chk("bdrop_order", order[i], exp_order[i]);

        // Stuck ROM: abort exactly TIMEOUT cycles after the strobe rises
        do_reset();
        rom_delay = 1000;
        ifc.a_addr = 32'h50; ifc.a_read_en = 1'b1; qa.push_back(rom_fn(32'h50));
        r = 0; f = 0; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #2; cyc++;
            if (ifc.rom_read_en) begin seen = 1'b1; r = cyc; end
        end
        chk("wd_rise_seen", seen, 1);
        seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(posedge clk); #2; cyc++;
            chk("wd_no_ready", ifc.a_ready, 0);
            if (!ifc.rom_read_en) begin seen = 1'b1; f = cyc; end
        end
        chk("wd_fall_seen", seen, 1);
        chk("wd_strobe_len", f - r, 10);
        chk("wd_a_err", ifc.a_err, 1);
        chk("wd_owner", ifc.owner, 0);
        chk("wd_timeout_err", ifc.timeout_err, 1);
        ifc.a_read_en = 1'b0;
        qa.delete();
        @(posedge clk); #2;
        chk("wd_err_pulse_end", ifc.a_err, 0);
        chk("wd_sticky", ifc.timeout_err, 1);
        rom_delay = 1;
        serve(1, 32'h60, 0, 0, 32'h0, 0, 50);
        chk("wd_recover_len", order.size(), 1);
        chk("wd_sticky_after", ifc.timeout_err, 1);

        // Ready on the expiry cycle wins over the abort
        do_reset();
        rom_delay = 9;
        serve(1, 32'h70, 0, 0, 32'h0, 0, 50);
        chk("edge_len", order.size(), 1);
        if (acyc.size() == 1) chk("edge_latency", acyc[0], 10);
        @(posedge clk); #2;
        chk("edge_no_err", ifc.a_err, 0);
        chk("edge_timeout_err", ifc.timeout_err, 0);

        // Asynchronous reset while BUSY discards the access
        do_reset();
        rom_delay = 1;
        ifc.a_addr = 32'h40; ifc.a_read_en = 1'b1;
        @(posedge clk); #2;
        chk("ar_busy", ifc.rom_read_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_rom_read_en", ifc.rom_read_en, 0);
        chk("ar_owner", ifc.owner, 0);
        chk("ar_ready", ifc.a_ready, 0);
        ifc.a_read_en = 1'b0;
        repeat (2) begin
            @(posedge clk); #2;
            chk("ar_no_pulse", {ifc.a_ready, ifc.a_err}, 0);
        end
        rst_n = 1'b1;
        serve(1, 32'h44, 0, 0, 32'h0, 0, 50);
        chk("ar_recover_len", order.size(), 1);
        chk("ar_no_timeout", ifc.timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
